fryer_key_ctrl: RTL and testbench
=================================

FRYER_KEY_CTRL -- requirements
Module: fryer_key_ctrl

Interface
REQ-001 SHALL provide parameter TEMP_DEF, default 180, power-on temperature setpoint in degrees C.
REQ-002 SHALL provide parameter TEMP_MIN, default 80, lowest settable temperature.
REQ-003 SHALL provide parameter TEMP_MAX, default 200, highest settable temperature.
REQ-004 SHALL provide parameter TEMP_STEP, default 10, temperature increment per key press.
REQ-005 SHALL provide parameter TIME_DEF, default 15, power-on cook time in minutes; the settable range is 1..TIME_MAX.
REQ-006 SHALL provide parameter TIME_MAX, default 60, longest settable cook time in minutes.
REQ-007 SHALL provide parameter BEEP_S, default 3, buzzer duration in tick_1s periods.
REQ-008 clk  input  1  system clock.
REQ-009 rst  input  1  reset; asynchronous, active-low.
REQ-010 key_pulse  input  6  single-cycle active-high key events from the debouncer; bit0 power, bit1 start/pause, bit2 temp+, bit3 temp-, bit4 time+, bit5 time-.
REQ-011 tick_1s  input  1  single-cycle pulse, once per second.
REQ-012 state  output  3  OFF=0, SET=1, RUN=2, PAUSE=3, DONE=4.
REQ-013 temp_set  output  8  current temperature setpoint.
REQ-014 time_set  output  6  current cook time setpoint, in minutes.
REQ-015 rem_min, rem_sec  output  6 each  remaining time, mm:ss.
REQ-016 heater_on, fan_on, buzzer  output  1 each  actuator enables.

Function
REQ-017 All outputs SHALL be registered and updated on the clk edge that samples the triggering event; latency is 1 cycle.
REQ-018 Key priority SHALL be power > start > temp+ > temp- > time+ > time-; when several bits are set in one cycle, only the highest-priority bit acts.
REQ-019 OFF state:
- power -> SET; temp_set=TEMP_DEF, time_set=TIME_DEF, rem=TIME_DEF:00.
- All other keys and ticks ignored.
REQ-020 SET state:
- power -> OFF.
- start -> RUN.
- temp+/temp- change temp_set by TEMP_STEP, saturating at TEMP_MAX/TEMP_MIN.
- time+/time- change time_set by 1, saturating at TIME_MAX/1.
- Every time change reloads rem=time_set:00 in the same cycle.
REQ-021 RUN state:
- Each tick_1s decrements rem, with rem_sec borrowing from rem_min (mm:00 -> (mm-1):59).
- A tick at 00:01 -> rem=00:00 and state DONE.
- start -> PAUSE; power -> OFF.
- temp/time keys ignored.
REQ-022 If start and tick_1s coincide in RUN, the decrement SHALL still occur and the state goes to PAUSE, unless the decrement reaches 00:00, in which case DONE wins.
REQ-023 PAUSE state:
- start -> RUN; power -> OFF.
- tick_1s and temp/time keys ignored; rem is held.
REQ-024 DONE state:
- buzzer=1; counts BEEP_S ticks, then -> SET with rem=time_set:00 and buzzer=0.
- start -> SET immediately (same reload).
- power -> OFF.
REQ-025 Entering OFF SHALL clear rem to 00:00 and deassert heater_on, fan_on and buzzer.
REQ-026 Outputs SHALL be heater_on=(state==RUN), fan_on=(state==RUN or PAUSE or DONE), buzzer=(state==DONE).
REQ-027 Unused state encodings SHALL return to OFF on the next clock.

Reset
REQ-028 While rst=0, the block SHALL force state=OFF, temp_set=TEMP_DEF, time_set=TIME_DEF, rem=00:00, heater_on=fan_on=buzzer=0, and beep counter=0, regardless of clk.
REQ-029 Reset asserted mid-RUN SHALL abort immediately; after release the block SHALL require a power key press to leave OFF.

Verification
REQ-030 Reset, power pulse -> state=1, temp_set=180, time_set=15, rem=15:00, all actuators 0.
REQ-031 In SET, press temp+ three times -> 200 (saturated); press time- twenty times -> time_set=1, rem=01:00.
REQ-032 time_set=1, start, 60 ticks -> rem steps 00:59..00:00, state=4, heater_on=0, buzzer=1; 3 more ticks -> state=1, rem=01:00.
REQ-033 In RUN at 00:30, start coincident with tick -> state=3, rem=00:29; 5 ticks -> rem still 00:29; start -> RUN.
REQ-034 In SET, key_pulse=6'b000011 in one cycle -> state=0 (power wins), rem=00:00.
REQ-035 In RUN, assert rst=0 between clock edges -> outputs reach reset values asynchronously; after release, ticks and start are ignored and state stays 0.

Source files
------------

// File: rtl/fryer_key_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fryer_key_ctrl
// Description : Air-fryer keypad controller: setpoints, mm:ss countdown,
//               run/pause/done sequencing and actuator enables.
// Revision    : 1.0
// ============================================================================
module fryer_key_ctrl #(
    parameter int TEMP_DEF  = 180,
    parameter int TEMP_MIN  = 80,
    parameter int TEMP_MAX  = 200,
    parameter int TEMP_STEP = 10,
    parameter int TIME_DEF  = 15,
    parameter int TIME_MAX  = 60,
    parameter int BEEP_S    = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] key_pulse,
    input  logic       tick_1s,
    output logic [2:0] state,
    output logic [7:0] temp_set,
    output logic [5:0] time_set,
    output logic [5:0] rem_min,
    output logic [5:0] rem_sec,
    output logic       heater_on,
    output logic       fan_on,
    output logic       buzzer
);

    localparam logic [2:0] C_ST_OFF   = 3'd0;
    localparam logic [2:0] C_ST_SET   = 3'd1;
    localparam logic [2:0] C_ST_RUN   = 3'd2;
    localparam logic [2:0] C_ST_PAUSE = 3'd3;
    localparam logic [2:0] C_ST_DONE  = 3'd4;

    localparam logic [7:0] C_TEMP_DEF  = 8'(TEMP_DEF);
    localparam logic [7:0] C_TEMP_MIN  = 8'(TEMP_MIN);
    localparam logic [7:0] C_TEMP_MAX  = 8'(TEMP_MAX);
    localparam logic [7:0] C_TEMP_STEP = 8'(TEMP_STEP);
    localparam logic [8:0] C_TEMP_MIN9 = 9'(TEMP_MIN);
    localparam logic [8:0] C_TEMP_MAX9 = 9'(TEMP_MAX);
    localparam logic [8:0] C_TEMP_STP9 = 9'(TEMP_STEP);
    localparam logic [5:0] C_TIME_DEF  = 6'(TIME_DEF);
    localparam logic [5:0] C_TIME_MAX  = 6'(TIME_MAX);

    localparam int              C_BEEP_W    = (BEEP_S < 2) ? 1 : $clog2(BEEP_S + 1);
    localparam logic [C_BEEP_W-1:0] C_BEEP_LAST = C_BEEP_W'(BEEP_S - 1);

    logic [2:0]          state_q,  state_d;
    logic [7:0]          temp_q,   temp_d;
    logic [5:0]          time_q,   time_d;
    logic [5:0]          min_q,    min_d;
    logic [5:0]          sec_q,    sec_d;
    logic [C_BEEP_W-1:0] beep_q,   beep_d;
    logic                heater_q, heater_d;
    logic                fan_q,    fan_d;
    logic                buzzer_q, buzzer_d;

    // One-hot decode of the winning key: lower bit index has priority.
    logic w_key_power, w_key_start, w_key_tup, w_key_tdn, w_key_mup, w_key_mdn;

    assign w_key_power = key_pulse[0];
    assign w_key_start = key_pulse[1] & ~key_pulse[0];
    assign w_key_tup   = key_pulse[2] & ~|key_pulse[1:0];
    assign w_key_tdn   = key_pulse[3] & ~|key_pulse[2:0];
    assign w_key_mup   = key_pulse[4] & ~|key_pulse[3:0];
    assign w_key_mdn   = key_pulse[5] & ~|key_pulse[4:0];

    logic [7:0] w_temp_up, w_temp_dn;
    logic [5:0] w_time_up, w_time_dn;

    assign w_temp_up = (({1'b0, temp_q} + C_TEMP_STP9) > C_TEMP_MAX9) ? C_TEMP_MAX
                                                                      : temp_q + C_TEMP_STEP;
    assign w_temp_dn = ({1'b0, temp_q} < (C_TEMP_MIN9 + C_TEMP_STP9)) ? C_TEMP_MIN
                                                                      : temp_q - C_TEMP_STEP;
    assign w_time_up = (time_q >= C_TIME_MAX) ? C_TIME_MAX : time_q + 6'd1;
    assign w_time_dn = (time_q <= 6'd1) ? 6'd1 : time_q - 6'd1;

    logic       w_rem_last;
    logic [5:0] w_dec_min, w_dec_sec;

    assign w_rem_last = (min_q == 6'd0) && (sec_q <= 6'd1);
    assign w_dec_min  = (sec_q == 6'd0) ? min_q - 6'd1 : min_q;
    assign w_dec_sec  = (sec_q == 6'd0) ? 6'd59 : sec_q - 6'd1;

    always_comb begin
        state_d = state_q;
        temp_d  = temp_q;
        time_d  = time_q;
        min_d   = min_q;
        sec_d   = sec_q;
        beep_d  = beep_q;

        case (state_q)
            C_ST_OFF: begin
                if (w_key_power) begin
                    state_d = C_ST_SET;
                    temp_d  = C_TEMP_DEF;
                    time_d  = C_TIME_DEF;
                    min_d   = C_TIME_DEF;
                    sec_d   = 6'd0;
                end
            end
            C_ST_SET: begin
                if (w_key_power) begin
                    state_d = C_ST_OFF;
                    min_d   = 6'd0;
                    sec_d   = 6'd0;
                end else if (w_key_start) begin
                    state_d = C_ST_RUN;
                end else if (w_key_tup) begin
                    temp_d = w_temp_up;
                end else if (w_key_tdn) begin
                    temp_d = w_temp_dn;
                end else if (w_key_mup) begin
                    time_d = w_time_up;
                    min_d  = w_time_up;
                    sec_d  = 6'd0;
                end else if (w_key_mdn) begin
                    time_d = w_time_dn;
                    min_d  = w_time_dn;
                    sec_d  = 6'd0;
                end
            end
            C_ST_RUN: begin
                if (w_key_power) begin
                    state_d = C_ST_OFF;
                    min_d   = 6'd0;
                    sec_d   = 6'd0;
                end else if (tick_1s) begin
                    // Reaching 00:00 overrides a coincident pause request.
                    if (w_rem_last) begin
                        state_d = C_ST_DONE;
                        min_d   = 6'd0;
                        sec_d   = 6'd0;
                        beep_d  = '0;
                    end else begin
                        min_d = w_dec_min;
                        sec_d = w_dec_sec;
                        if (w_key_start) begin
                            state_d = C_ST_PAUSE;
                        end
                    end
                end else if (w_key_start) begin
                    state_d = C_ST_PAUSE;
                end
            end
            C_ST_PAUSE: begin
                if (w_key_power) begin
                    state_d = C_ST_OFF;
                    min_d   = 6'd0;
                    sec_d   = 6'd0;
                end else if (w_key_start) begin
                    state_d = C_ST_RUN;
                end
            end
            C_ST_DONE: begin
                if (w_key_power) begin
                    state_d = C_ST_OFF;
                    min_d   = 6'd0;
                    sec_d   = 6'd0;
                    beep_d  = '0;
                end else if (w_key_start || (tick_1s && (beep_q >= C_BEEP_LAST))) begin
                    state_d = C_ST_SET;
                    min_d   = time_q;
                    sec_d   = 6'd0;
                    beep_d  = '0;
                end else if (tick_1s) begin
                    beep_d = beep_q + 1'b1;
                end
            end
            default: begin
                state_d = C_ST_OFF;
                min_d   = 6'd0;
                sec_d   = 6'd0;
                beep_d  = '0;
            end
        endcase

        heater_d = (state_d == C_ST_RUN);
        fan_d    = (state_d == C_ST_RUN) || (state_d == C_ST_PAUSE) || (state_d == C_ST_DONE);
        buzzer_d = (state_d == C_ST_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= C_ST_OFF;
            temp_q   <= C_TEMP_DEF;
            time_q   <= C_TIME_DEF;
            min_q    <= 6'd0;
            sec_q    <= 6'd0;
            beep_q   <= '0;
            heater_q <= 1'b0;
            fan_q    <= 1'b0;
            buzzer_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            temp_q   <= temp_d;
            time_q   <= time_d;
            min_q    <= min_d;
            sec_q    <= sec_d;
            beep_q   <= beep_d;
            heater_q <= heater_d;
            fan_q    <= fan_d;
            buzzer_q <= buzzer_d;
        end
    end

    assign state     = state_q;
    assign temp_set  = temp_q;
    assign time_set  = time_q;
    assign rem_min   = min_q;
    assign rem_sec   = sec_q;
    assign heater_on = heater_q;
    assign fan_on    = fan_q;
    assign buzzer    = buzzer_q;

endmodule
`default_nettype wire

// File: tb/tb_fryer_key_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fryer_key_ctrl
// Description : Directed and randomized bench for fryer_key_ctrl against a
//               seconds-based behavioural model.
// Revision    : 1.0
// ============================================================================
module tb_fryer_key_ctrl;

    localparam int TEMP_DEF  = 180;
    localparam int TEMP_MIN  = 80;
    localparam int TEMP_MAX  = 200;
    localparam int TEMP_STEP = 10;
    localparam int TIME_DEF  = 15;
    localparam int TIME_MAX  = 60;
    localparam int BEEP_S    = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [5:0] key_pulse = 6'd0;
    logic       tick_1s = 1'b0;
    logic [2:0] state;
    logic [7:0] temp_set;
    logic [5:0] time_set, rem_min, rem_sec;
    logic       heater_on, fan_on, buzzer;

    fryer_key_ctrl #(
        .TEMP_DEF (TEMP_DEF),
        .TEMP_MIN (TEMP_MIN),
        .TEMP_MAX (TEMP_MAX),
        .TEMP_STEP(TEMP_STEP),
        .TIME_DEF (TIME_DEF),
        .TIME_MAX (TIME_MAX),
        .BEEP_S   (BEEP_S)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .key_pulse(key_pulse),
        .tick_1s  (tick_1s),
        .state    (state),
        .temp_set (temp_set),
        .time_set (time_set),
        .rem_min  (rem_min),
        .rem_sec  (rem_sec),
        .heater_on(heater_on),
        .fan_on   (fan_on),
        .buzzer   (buzzer)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: state number, setpoints, remaining time as total seconds.
    int m_state, m_temp, m_time, m_rem, m_beep;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int winning_key(input logic [5:0] k);
        for (int i = 0; i < 6; i++) begin
            if (k[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_state = 0; m_temp = TEMP_DEF; m_time = TIME_DEF; m_rem = 0; m_beep = 0;
    endtask

    task automatic model_step(input logic [5:0] k, input logic t);
        int a;
        a = winning_key(k);
        if (m_state != 0 && a == 0) begin
            m_state = 0; m_rem = 0;
        end else begin
            case (m_state)
                0: if (a == 0) begin
                    m_state = 1; m_temp = TEMP_DEF; m_time = TIME_DEF; m_rem = TIME_DEF * 60;
                end
                1: case (a)
                    1: m_state = 2;
                    2: m_temp = (m_temp + TEMP_STEP > TEMP_MAX) ? TEMP_MAX : m_temp + TEMP_STEP;
                    3: m_temp = (m_temp - TEMP_STEP < TEMP_MIN) ? TEMP_MIN : m_temp - TEMP_STEP;
                    4: begin m_time = (m_time >= TIME_MAX) ? TIME_MAX : m_time + 1; m_rem = m_time * 60; end
                    5: begin m_time = (m_time <= 1) ? 1 : m_time - 1; m_rem = m_time * 60; end
                    default: ;
                endcase
                2: begin
                    if (t) m_rem = m_rem - 1;
                    if (t && m_rem == 0) begin
                        m_state = 4; m_beep = 0;
                    end else if (a == 1) begin
                        m_state = 3;
                    end
                end
                3: if (a == 1) m_state = 2;
                4: begin
                    if (a == 1) begin
                        m_state = 1; m_rem = m_time * 60;
                    end else if (t) begin
                        m_beep++;
                        if (m_beep == BEEP_S) begin
                            m_state = 1; m_rem = m_time * 60;
                        end
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic compare_all();
        check("state",  32'(state),     32'(m_state));
        check("temp",   32'(temp_set),  32'(m_temp));
        check("time",   32'(time_set),  32'(m_time));
        check("remmin", 32'(rem_min),   32'(m_rem / 60));
        check("remsec", 32'(rem_sec),   32'(m_rem % 60));
        check("heater", 32'(heater_on), 32'(m_state == 2));
        check("fan",    32'(fan_on),    32'(m_state >= 2 && m_state <= 4));
        check("buzzer", 32'(buzzer),    32'(m_state == 4));
    endtask

    // Drive one cycle of stimulus, advance the model at the edge, compare after it.
    task automatic cycle(input logic [5:0] k, input logic t);
        key_pulse = k;
        tick_1s   = t;
        @(posedge clk);
        model_step(k, t);
        #1;
        key_pulse = 6'd0;
        tick_1s   = 1'b0;
        compare_all();
    endtask

    initial begin
        model_reset();
        #12;
        compare_all();
        rst = 1'b1;
        @(posedge clk); #1;
        compare_all();

        // Power-up into SET.
        cycle(6'b000001, 1'b0);
        check("pwr_state", 32'(state), 32'd1);
        check("pwr_rem",   32'(rem_min), 32'd15);

        for (int i = 0; i < 3; i++) cycle(6'b000100, 1'b0);
        check("temp_sat", 32'(temp_set), 32'd200);
        for (int i = 0; i < 20; i++) cycle(6'b100000, 1'b0);
        check("time_min", 32'(time_set), 32'd1);
        check("rem_1min", 32'(rem_min), 32'd1);

        // Full countdown from 01:00 and the buzzer interval.
        cycle(6'b000010, 1'b0);
        for (int i = 0; i < 60; i++) cycle(6'b000000, 1'b1);
        check("done_state", 32'(state), 32'd4);
        check("done_buzz",  32'(buzzer), 32'd1);
        for (int i = 0; i < 3; i++) cycle(6'b000000, 1'b1);
        check("done_back", 32'(state), 32'd1);
        check("done_rem",  32'(rem_min), 32'd1);

        // Pause coincident with a tick at 00:30.
        cycle(6'b000010, 1'b0);
        for (int i = 0; i < 30; i++) cycle(6'b000000, 1'b1);
        cycle(6'b000010, 1'b1);
        check("pause_state", 32'(state), 32'd3);
        check("pause_sec",   32'(rem_sec), 32'd29);
        for (int i = 0; i < 5; i++) cycle(6'b000000, 1'b1);
        check("pause_hold", 32'(rem_sec), 32'd29);
        cycle(6'b000010, 1'b0);
        check("resume", 32'(state), 32'd2);

        // Power beats start in SET.
        cycle(6'b000001, 1'b0);
        cycle(6'b000001, 1'b0);
        cycle(6'b000011, 1'b0);
        check("prio_off", 32'(state), 32'd0);

        // Asynchronous reset mid-RUN, then stay OFF without a power key.
        cycle(6'b000001, 1'b0);
        cycle(6'b000010, 1'b0);
        for (int i = 0; i < 4; i++) cycle(6'b000000, 1'b1);
        #1;
        rst = 1'b0;
        model_reset();
        #1;
        compare_all();
        #1;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) cycle(6'b000010, 1'b1);
        check("rst_off", 32'(state), 32'd0);

        // Randomized key/tick traffic.
        for (int n = 0; n < 4000; n++) begin
            int         r;
            logic [5:0] k;
            logic [31:0] rv;
            r  = int'($urandom_range(0, 199));
            rv = $urandom;
            if (r < 3)       k = 6'b000001;
            else if (r < 30) k = 6'(6'b000001 << $urandom_range(1, 5));
            else if (r < 34) k = rv[5:0];
            else if (r < 40) k = 6'b100000;
            else             k = 6'b000000;
            cycle(k, ($urandom_range(0, 2) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
